// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the sequential multiplier.
//   WIDTH   : default operand width (product is 2*WIDTH)
//   ITERS   : number of shift-add iterations
//   state_t : control FSM state encoding (2 bits)
package seq_multiplier_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/RippleCarryAdder.sv
// Plain ripple-carry adder used by the multiplier datapath.
//   a, b     : WIDTH-bit addends
//   carryin  : carry into bit 0
//   sum      : WIDTH-bit sum
//   carryout : carry out of the top bit
module RippleCarryAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
);

    logic carry_s;

    // Bit-serial carry propagation from LSB to MSB.
    always_comb begin
        carry_s = carryin;
        sum     = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]  = a[i] ^ b[i] ^ carry_s;
            carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
        end
        carryout = carry_s;
    end

endmodule

// File: rtl/mult_abs.sv
// Conditional two's-complement negate, used to form operand magnitudes.
//   value     : WIDTH-bit input
//   negate    : 1 = output ~value+1, 0 = pass value through
//   magnitude : WIDTH-bit result (most negative value maps to itself,
//               which is its correct unsigned magnitude)
module mult_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] magnitude
);

    // Select between the input and its two's-complement negation.
    always_comb begin
        magnitude = value;
        if (negate) begin
            magnitude = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = value;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Operands are converted to magnitudes at start, multiplied unsigned over
// ITERS iterations, and the sign is reapplied in a final FIX cycle.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : operation request, honoured only in IDLE
//   signed_op : 1 = two's-complement operands, 0 = unsigned
//   a, b      : multiplicand / multiplier, sampled with start
//   busy      : high while in CALC and FIX
//   done      : one-cycle pulse in DONE
//   product   : registered 2*WIDTH result, held until the next FIX
module seq_multiplier #(
    parameter int WIDTH = seq_multiplier_pkg::WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import seq_multiplier_pkg::*;

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mag_a_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;
    logic [WIDTH:0]       upper_s;
    logic                 busy_next_s;
    logic                 done_next_s;

    mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value     (a),
        .negate    (signed_op & a[WIDTH-1]),
        .magnitude (abs_a_s)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value     (b),
        .negate    (signed_op & b[WIDTH-1]),
        .magnitude (abs_b_s)
    );

    // The upper accumulator half plus the latched |a| is the only add per iteration.
    RippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
        .a        (acc_r[2*WIDTH-1:WIDTH]),
        .b        (mag_a_r),
        .carryin  (1'b0),
        .sum      (sum_s),
        .carryout (cout_s)
    );

    // New upper 33 bits: add |a| only when the current multiplier LSB is set.
    always_comb begin
        upper_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        if (acc_r[0]) begin
            upper_s = {cout_s, sum_s};
        end else begin
            upper_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
    end

    // Next-state logic and the decoded values of the registered status outputs.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (count_r == CNT_LAST) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
        busy_next_s = (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
        done_next_s = (state_next_s == ST_DONE);
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Datapath: operand latch, shift-add iterations and final sign fix-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            mag_a_r   <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mag_a_r <= abs_a_s;
                        neg_r   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_r   <= {{WIDTH{1'b0}}, abs_b_s};
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    acc_r   <= {upper_s, acc_r[WIDTH-1:1]};
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    if (neg_r) begin
                        product_r <= ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        product_r <= acc_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int total;
    int bad;

    seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: extend both operands to 64 bits and multiply; low 64 bits are exact.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive one operation and observe it over 35 edges after the start edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          output logic [63:0] p, output int lat, output int n_done,
                          output int busy_bad);
        @(negedge clk);
        a = ta; b = tb_v; signed_op = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_op = 1'($urandom_range(0, 1));
        lat = -1; n_done = 0; busy_bad = 0; p = 64'd0;
        if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) begin
                    lat = k;
                    p = product;
                end
            end
            if (busy !== (k <= 32)) busy_bad++;
            if (busy === 1'b1 && done === 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (product !== 64'd0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vs [6];
        logic [63:0] ve [6];
        logic [63:0] p;
        int lat, nd, bb;
        va[0] = 32'd3;          vb[0] = 32'd5;          vs[0] = 1'b0; ve[0] = 64'h0000_0000_0000_000F;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vs[1] = 1'b0; ve[1] = 64'hFFFF_FFFE_0000_0001;
        va[2] = 32'hFFFF_FFFD;  vb[2] = 32'd7;          vs[2] = 1'b1; ve[2] = 64'hFFFF_FFFF_FFFF_FFEB;
        va[3] = 32'hFFFF_FFFD;  vb[3] = 32'd7;          vs[3] = 1'b0; ve[3] = 64'h0000_0006_FFFF_FFEB;
        va[4] = 32'h8000_0000;  vb[4] = 32'h8000_0000;  vs[4] = 1'b1; ve[4] = 64'h4000_0000_0000_0000;
        va[5] = 32'h8000_0000;  vb[5] = 32'd1;          vs[5] = 1'b1; ve[5] = 64'hFFFF_FFFF_8000_0000;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], p, lat, nd, bb);
            total++; if (p !== ve[i]) begin bad++; $display("FAIL dir_product[%0d] got=%h exp=%h", i, p, ve[i]); end
            total++; if (lat !== 33) begin bad++; $display("FAIL dir_latency[%0d] got=%0d exp=33", i, lat); end
            total++; if (nd !== 1) begin bad++; $display("FAIL dir_done_count[%0d] got=%0d exp=1", i, nd); end
            total++; if (bb !== 0) begin bad++; $display("FAIL dir_busy_profile[%0d] errors=%0d exp=0", i, bb); end
            total++; if (product !== ve[i]) begin bad++; $display("FAIL dir_product_hold[%0d] got=%h exp=%h", i, product, ve[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] p, exp_p;
        int lat, nd, bb;
        for (int i = 0; i < 24; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            exp_p = ref_mul(ra, rb, rs);
            run_op(ra, rb, rs, p, lat, nd, bb);
            total++;
            if (p !== exp_p || lat !== 33 || nd !== 1 || bb !== 0) begin
                bad++;
                $display("FAIL rand[%0d] a=%h b=%h s=%b got=%h exp=%h lat=%0d dones=%0d busy_err=%0d",
                         i, ra, rb, rs, p, exp_p, lat, nd, bb);
            end
        end
    endtask

    task automatic test_ignored_start();
        int nd;
        logic [63:0] got;
        got = 64'd0;
        nd = 0;
        @(negedge clk);
        a = 32'd6; b = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                nd++;
                got = product;
                start = 1'b1; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++; if (nd !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", nd); end
        total++; if (got !== 64'd42) begin bad++; $display("FAIL ign_product got=%h exp=%h", got, 64'd42); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
        total++; if (product !== 64'd42) begin bad++; $display("FAIL ign_product_hold got=%h exp=%h", product, 64'd42); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] p;
        int lat, nd, bb;
        @(negedge clk);
        a = 32'd6; b = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        total++; if (product !== 64'd0) begin bad++; $display("FAIL rstmid_product got=%h exp=0", product); end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd2, 32'd2, 1'b0, p, lat, nd, bb);
        total++; if (p !== 64'd4) begin bad++; $display("FAIL rstmid_after_product got=%h exp=%h", p, 64'd4); end
        total++; if (lat !== 33) begin bad++; $display("FAIL rstmid_after_latency got=%0d exp=33", lat); end
        total++; if (nd !== 1 || bb !== 0) begin bad++; $display("FAIL rstmid_after_handshake dones=%0d busy_err=%0d exp=1/0", nd, bb); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
